// File: rtl/mul_pkg.sv
// Shared constants and FSM state type for the sequential shift-add multiplier.
package mul_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_multiplier_csa.sv
// 32-bit carry-select adder: 4-bit blocks precompute both carry-in cases,
// and the ripple between blocks is only a chain of muxes.
module shift_add_multiplier_csa (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout
);

  localparam int BLK  = 4;
  localparam int NBLK = 32 / BLK;

  logic [NBLK:0] w_carry;

  assign w_carry[0] = Cin;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] w_sum0;
    logic [BLK:0] w_sum1;

    assign w_sum0 = {1'b0, A[g*BLK +: BLK]} + {1'b0, B[g*BLK +: BLK]};
    assign w_sum1 = {1'b0, A[g*BLK +: BLK]} + {1'b0, B[g*BLK +: BLK]} + (BLK+1)'(1);

    assign S[g*BLK +: BLK] = w_carry[g] ? w_sum1[BLK-1:0] : w_sum0[BLK-1:0];
    assign w_carry[g+1]    = w_carry[g] ? w_sum1[BLK]     : w_sum0[BLK];
  end

  assign Cout = w_carry[NBLK];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned 32x32->64 radix-2 shift-add multiplier, one partial
// product per cycle through a shared carry-select adder, valid/ready on both sides.
module shift_add_multiplier #(
  parameter int WIDTH     = mul_pkg::WIDTH,
  parameter int ZERO_SKIP = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  import mul_pkg::*;

  if (WIDTH != mul_pkg::WIDTH) begin : g_width_check
    $error("shift_add_multiplier: WIDTH must be 32, the adder is fixed at 32 bits");
  end

  state_e               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic [CNT_W-1:0]     r_count;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;

  assign w_addend = r_acc_lo[0] ? r_mcand : '0;

  shift_add_multiplier_csa u_adder (
    .A    (r_acc_hi),
    .B    (w_addend),
    .Cin  (1'b0),
    .S    (w_sum),
    .Cout (w_cout)
  );

  // NOTE: every register here is written with <= so all next-state values
  // are computed from the same pre-edge snapshot, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mcand     <= '0;
      r_acc_hi    <= '0;
      r_acc_lo    <= '0;
      r_count     <= '0;
      r_product   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_mcand    <= a;
            r_acc_hi   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (ZERO_SKIP != 0 && (a == '0 || b == '0)) begin
              r_acc_lo  <= '0;
              r_product <= '0;
              r_state   <= DONE;
            end else begin
              r_acc_lo <= b;
              r_state  <= CALC;
            end
          end
        end

        CALC: begin
          // The 33-bit sum shifts right by one, so Cout lands in the top bit.
          r_acc_hi  <= {w_cout, w_sum[WIDTH-1:1]};
          r_acc_lo  <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
          r_product <= {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};
          r_count   <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_state <= DONE;
          end
        end

        DONE: begin
          // out_valid trails DONE entry by one cycle and then holds until taken.
          if (r_out_valid && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_out_valid <= 1'b1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign busy      = r_busy;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed corner cases plus 1000 random products compared
// against plain 64-bit arithmetic; a second instance covers the no-skip variant.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_ready;

  logic        in_valid,  in_ready,  out_valid,  busy;
  logic [63:0] product;
  logic        in_valid_nz, in_ready_nz, out_valid_nz, busy_nz;
  logic [63:0] product_nz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(32), .ZERO_SKIP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  shift_add_multiplier #(.WIDTH(32), .ZERO_SKIP(0)) dut_nz (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_nz),
    .in_ready  (in_ready_nz),
    .a         (a),
    .b         (b),
    .out_valid (out_valid_nz),
    .out_ready (out_ready),
    .product   (product_nz),
    .busy      (busy_nz)
  );

  function automatic logic [63:0] model_product(input logic [31:0] x, input logic [31:0] y);
    return {32'd0, x} * {32'd0, y};
  endfunction

  function automatic int model_latency(input bit skip, input logic [31:0] x, input logic [31:0] y);
    return (skip && (x == 32'd0 || y == 32'd0)) ? 1 : 33;
  endfunction

  // Called at a falling edge; returns at the falling edge right after the accepting edge.
  task automatic launch(input bit nz, input logic [31:0] op_a, input logic [31:0] op_b);
    int guard;
    guard = 0;
    while (((nz ? in_ready_nz : in_ready) !== 1'b1) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL launch_ready in_ready stayed %b for 200 cycles, need 1", nz ? in_ready_nz : in_ready);
    end
    a = op_a;
    b = op_b;
    if (nz) in_valid_nz = 1'b1;
    else    in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    in_valid_nz = 1'b0;
  endtask

  task automatic wait_out(input bit nz, input bit rand_ready, output int lat, output logic [63:0] prod);
    lat = 0;
    do begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (((nz ? out_valid_nz : out_valid) !== 1'b1) && lat < 200);
    prod = nz ? product_nz : product;
    checks++;
    if (lat >= 200) begin
      errors++;
      $display("FAIL wait_out_timeout out_valid not seen within 200 cycles, need it within 33");
    end
  endtask

  task automatic consume(input bit nz, input int stalls, input logic [63:0] exp);
    logic        ov, rdy, bz;
    logic [63:0] pr;
    for (int i = 0; i < stalls; i++) begin
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ov = nz ? out_valid_nz : out_valid;
      pr = nz ? product_nz : product;
      checks++;
      if (ov !== 1'b1 || pr !== exp) begin
        errors++;
        $display("FAIL stall_hold out_valid=%b product=%h, need out_valid=1 product=%h", ov, pr, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ov  = nz ? out_valid_nz : out_valid;
    rdy = nz ? in_ready_nz : in_ready;
    bz  = nz ? busy_nz : busy;
    checks++;
    if (ov !== 1'b0 || rdy !== 1'b1 || bz !== 1'b0) begin
      errors++;
      $display("FAIL release out_valid=%b in_ready=%b busy=%b, need 0 1 0", ov, rdy, bz);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_valid_nz = 1'b0;
    out_ready   = 1'b1;
    a           = 32'd0;
    b           = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b need 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b need 0", busy); end
    checks++;
    if (product !== 64'd0) begin errors++; $display("FAIL reset_product got %h need 0", product); end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b need 1", in_ready); end
  endtask

  task automatic test_basic();
    int          lat;
    logic [63:0] prod;
    launch(0, 32'd3, 32'd5);
    wait_out(0, 0, lat, prod);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL basic_3x5_latency got %0d need 33", lat); end
    checks++;
    if (prod !== 64'h000000000000000F) begin errors++; $display("FAIL basic_3x5_product got %h need 000000000000000f", prod); end
    consume(0, 0, 64'h000000000000000F);

    launch(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_out(0, 0, lat, prod);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL basic_max_latency got %0d need 33", lat); end
    checks++;
    if (prod !== 64'hFFFFFFFE00000001) begin errors++; $display("FAIL basic_max_product got %h need fffffffe00000001", prod); end
    consume(0, 0, 64'hFFFFFFFE00000001);
  endtask

  task automatic test_zero_skip();
    int          lat;
    logic [63:0] prod;
    launch(0, 32'd0, 32'h12345678);
    wait_out(0, 0, lat, prod);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL zskip_a0_latency got %0d need 1", lat); end
    checks++;
    if (prod !== 64'd0) begin errors++; $display("FAIL zskip_a0_product got %h need 0", prod); end
    consume(0, 0, 64'd0);

    launch(0, 32'h12345678, 32'd0);
    wait_out(0, 0, lat, prod);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL zskip_b0_latency got %0d need 1", lat); end
    checks++;
    if (prod !== 64'd0) begin errors++; $display("FAIL zskip_b0_product got %h need 0", prod); end
    consume(0, 0, 64'd0);

    launch(1, 32'd0, 32'h12345678);
    wait_out(1, 0, lat, prod);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL noskip_latency got %0d need 33", lat); end
    checks++;
    if (prod !== 64'd0) begin errors++; $display("FAIL noskip_product got %h need 0", prod); end
    consume(1, 0, 64'd0);
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [63:0] prod;
    out_ready = 1'b0;
    launch(0, 32'h80000000, 32'd2);
    wait_out(0, 0, lat, prod);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL bp_latency got %0d need 33", lat); end
    checks++;
    if (prod !== 64'h0000000100000000) begin errors++; $display("FAIL bp_product got %h need 0000000100000000", prod); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (product !== 64'h0000000100000000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold product=%h out_valid=%b in_ready=%b, need 0000000100000000 1 0", product, out_valid, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release in_ready=%b out_valid=%b busy=%b, need 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [63:0] prod;
    launch(0, 32'h00001234, 32'h00005678);
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || product !== 64'd0) begin
      errors++;
      $display("FAIL midreset_clear out_valid=%b in_ready=%b busy=%b product=%h, need 0 0 0 0", out_valid, in_ready, busy, product);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_hold in_ready=%b out_valid=%b, need 0 0", in_ready, out_valid);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
    end
    launch(0, 32'd7, 32'd9);
    wait_out(0, 0, lat, prod);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL midreset_7x9_latency got %0d need 33", lat); end
    checks++;
    if (prod !== 64'd63) begin errors++; $display("FAIL midreset_7x9_product got %h need 000000000000003f", prod); end
    consume(0, 0, 64'd63);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'h80000000;
      3:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int          lat;
    logic [63:0] prod;
    logic [63:0] exp;
    logic [31:0] ra;
    logic [31:0] rb;
    for (int n = 0; n < 1000; n++) begin
      ra  = pick_operand();
      rb  = pick_operand();
      exp = model_product(ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      launch(0, ra, rb);
      wait_out(0, 1, lat, prod);
      checks++;
      if (lat != model_latency(1'b1, ra, rb)) begin
        errors++;
        $display("FAIL rand_latency %h*%h got %0d need %0d", ra, rb, lat, model_latency(1'b1, ra, rb));
      end
      checks++;
      if (prod !== exp) begin
        errors++;
        $display("FAIL rand_product %h*%h got %h need %h", ra, rb, prod, exp);
      end
      consume(0, $urandom_range(0, 3), exp);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_skip();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
